// File: rtl/hpi_responder.sv
// HPI device-side responder: word RAM, auto-increment pointer,
// two mailboxes and a status word behind the EZ-OTG host port.
//
// Ports:
//   Clk, Reset        clock, async active-low reset
//   OTG_DATA          bidirectional host data bus (driven on reads only)
//   OTG_ADDR          port select: 0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS
//   OTG_CS_N/RD_N/WR_N host strobes, active low
//   OTG_RST_N         synchronous soft reset, active low
//   OTG_INT           high while device-to-host mailbox is full
//   dev_mbx_*         local mailbox port (post d2h, consume h2d)
module hpi_responder #(
    parameter int MEM_WORDS = 256,
    parameter int AW        = 8
) (
    input  logic        Clk,
    input  logic        Reset,
    inout  wire  [15:0] OTG_DATA,
    input  logic [1:0]  OTG_ADDR,
    input  logic        OTG_CS_N,
    input  logic        OTG_RD_N,
    input  logic        OTG_WR_N,
    input  logic        OTG_RST_N,
    output logic        OTG_INT,
    input  logic [15:0] dev_mbx_in,
    input  logic        dev_mbx_wr,
    output logic [15:0] dev_mbx_out,
    output logic        dev_mbx_valid,
    input  logic        dev_mbx_ack
);

    logic        cs_q;
    logic        rd_q;
    logic        wr_q;
    logic [1:0]  addr_q;
    logic [15:0] data_q;

    logic [15:0] ptr;
    logic [15:0] h2d;
    logic        h2d_full;
    logic [15:0] d2h;
    logic        d2h_full;
    logic        ovf;
    logic [15:0] rdata;

    logic [15:0] mem [MEM_WORDS];

    logic [AW-1:0] idx;
    logic          drive;
    logic          wr_commit;
    logic          rd_start;
    logic          rd_end;
    logic [15:0]   rd_mux;

    assign idx = ptr[AW:1];

    // A previous cycle with both strobes low is an illegal overlap:
    // requiring the other strobe high in the previous cycle keeps the
    // rising edge that ends an overlap from committing anything.
    assign wr_commit = !cs_q && !wr_q && OTG_WR_N && rd_q;
    assign rd_end    = !cs_q && !rd_q && OTG_RD_N && wr_q;
    assign rd_start  = !OTG_CS_N && !OTG_RD_N && OTG_WR_N && rd_q;

    assign drive    = !cs_q && !rd_q && wr_q;
    assign OTG_DATA = drive ? rdata : 16'hzzzz;

    assign OTG_INT       = d2h_full;
    assign dev_mbx_out   = h2d;
    assign dev_mbx_valid = h2d_full;

    always_comb begin
        rd_mux = 16'h0000;
        case (OTG_ADDR)
            2'd0: rd_mux = mem[idx];
            2'd1: rd_mux = d2h;
            2'd2: rd_mux = ptr;
            2'd3: rd_mux = {13'b0, ovf, d2h_full, h2d_full};
            default: rd_mux = 16'h0000;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cs_q     <= 1'b1;
            rd_q     <= 1'b1;
            wr_q     <= 1'b1;
            addr_q   <= 2'd0;
            data_q   <= 16'h0000;
            ptr      <= 16'h0000;
            h2d      <= 16'h0000;
            h2d_full <= 1'b0;
            d2h      <= 16'h0000;
            d2h_full <= 1'b0;
            ovf      <= 1'b0;
            rdata    <= 16'h0000;
        end else begin
            cs_q   <= OTG_CS_N;
            rd_q   <= OTG_RD_N;
            wr_q   <= OTG_WR_N;
            addr_q <= OTG_ADDR;
            data_q <= OTG_DATA;
            if (!OTG_RST_N) begin
                ptr      <= 16'h0000;
                h2d      <= 16'h0000;
                h2d_full <= 1'b0;
                d2h      <= 16'h0000;
                d2h_full <= 1'b0;
                ovf      <= 1'b0;
                rdata    <= 16'h0000;
            end else begin
                if (rd_start)
                    rdata <= rd_mux;
                // ack first so a coinciding host write re-sets full
                if (dev_mbx_ack)
                    h2d_full <= 1'b0;
                if (wr_commit) begin
                    case (addr_q)
                        2'd0: ptr <= ptr + 16'd2;
                        2'd1: begin
                            h2d      <= data_q;
                            h2d_full <= 1'b1;
                            if (h2d_full)
                                ovf <= 1'b1;
                        end
                        2'd2: ptr <= data_q;
                        default: ;
                    endcase
                end
                if (rd_end) begin
                    case (addr_q)
                        2'd0: ptr <= ptr + 16'd2;
                        2'd1: d2h_full <= 1'b0;
                        2'd3: ovf <= 1'b0;
                        default: ;
                    endcase
                end
                // device post last so it wins over a mailbox read-end
                if (dev_mbx_wr) begin
                    d2h      <= dev_mbx_in;
                    d2h_full <= 1'b1;
                end
            end
        end
    end

    // RAM survives both resets
    always_ff @(posedge Clk) begin
        if (Reset && OTG_RST_N && wr_commit && addr_q == 2'd0)
            mem[idx] <= data_q;
    end

endmodule
